// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared fetch-path types and constants for the RV32I core.
package rv32i_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small power-of-two FIFO with synchronous flush and reset, no bypass.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  T            din,
    output T            dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (push != pop) r_count <= push ? r_count + (AW+1)'(1) : r_count - (AW+1)'(1);
        end
    end
    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_count == (AW+1)'(DEPTH);
    assign empty = r_count == '0;
    assign count = r_count;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches from IMEM into a FIFO and hands {pc, instr} to decode.
module instr_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [31:0] Instr_Addr,
    input  logic [31:0] Instr_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        misalign_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [31:0]   r_pc;
    logic          r_misalign;
    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_din;
    fetch_entry_t  w_head;
    assign Instr_Addr   = r_pc;
    assign out_valid    = !w_empty;
    assign w_pop        = out_valid && out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still sustains one fetch per cycle
    assign w_push       = fetch_en && !redirect_valid && (!w_full || w_pop);
    assign w_din        = '{pc: r_pc, instr: Instr_rdata};
    assign out_pc       = w_head.pc;
    assign out_instr    = w_head.instr;
    assign misalign_err = r_misalign;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            r_pc       <= redirect_valid ? {redirect_pc[31:2], 2'b00} : w_push ? r_pc + PC_STEP : r_pc;
        end
    end
    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (redirect_valid),
        .din     (w_din),
        .dout    (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );
    assert property (@(posedge clk) disable iff (!reset_n)
        w_count <= CW'(DEPTH) && w_empty == (w_count == '0));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table, hand-written corner sequence and a randomized queue-model run.
module tb_instr_fetch_unit;
    import rv32i_pkg::*;
    localparam int DEPTH = 2;
    logic        clk;
    logic        reset_n;
    logic        fetch_en;
    logic [31:0] Instr_Addr;
    logic [31:0] Instr_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        misalign_err;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        redir;
        logic        ready;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        e_chk;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;
    vec_t vecs[$];

    instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .Instr_Addr     (Instr_Addr),
        .Instr_rdata    (Instr_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h1234_50B7;
            32'h4:   return 32'hFFFF_F137;
            default: return (a * 32'h9E37_79B1) ^ INSTR_NOP;
        endcase
    endfunction

    assign Instr_rdata = imem(Instr_Addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic rv, input logic [31:0] rp, input logic rd);
        reset_n        = r;
        fetch_en       = e;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    fetch_entry_t q[$];
    logic [31:0]  m_pc;
    logic         m_mis;

    initial begin
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        // {rst_n, en, redir, ready, rpc, exp addr, exp valid, check data, exp pc, exp instr, exp misalign}
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0,         32'h0,               1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,         32'h4,         1'b1, 1'b1, 32'h0,         32'h1234_50B7,       1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,         32'h8,         1'b1, 1'b1, 32'h4,         32'hFFFF_F137,       1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'hC,         1'b1, 1'b1, 32'h4,         32'hFFFF_F137,       1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'hC,         1'b1, 1'b1, 32'h4,         32'hFFFF_F137,       1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'h40,        32'h40,        1'b0, 1'b0, 32'h0,         32'h0,               1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h44,        1'b1, 1'b1, 32'h40,        imem(32'h40),        1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 32'h42,        32'h40,        1'b0, 1'b0, 32'h0,         32'h0,               1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,         32'h44,        1'b1, 1'b1, 32'h40,        imem(32'h40),        1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,         32'h0,               1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, imem(32'hFFFF_FFFC), 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,         32'h4,         1'b1, 1'b1, 32'h0,         32'h1234_50B7,       1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         1'b1, 1'b1, 32'h0,         32'h1234_50B7,       1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h4,         1'b0, 1'b0, 32'h0,         32'h0,               1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h8,         1'b1, 1'b1, 32'h4,         32'hFFFF_F137,       1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'hC,         1'b1, 1'b1, 32'h4,         32'hFFFF_F137,       1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h42,        32'h0,         1'b0, 1'b1, 32'h0,         32'h0,               1'b0});
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
            step();
            chk($sformatf("vec%0d addr", i), Instr_Addr, vecs[i].e_addr);
            chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d misalign", i), 32'(misalign_err), 32'(vecs[i].e_mis));
            if (vecs[i].e_chk) begin
                chk($sformatf("vec%0d pc", i), out_pc, vecs[i].e_pc);
                chk($sformatf("vec%0d instr", i), out_instr, vecs[i].e_instr);
            end
        end

        // Backpressure from reset: FIFO saturates, PC parks at 0x8, then drains without gap or repeat
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("stall addr", Instr_Addr, 32'h8);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drain%0d valid", k), 32'(out_valid), 32'h1);
            chk($sformatf("drain%0d pc", k), out_pc, 32'(k * 4));
            step();
        end

        // Randomized run against a queue model
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        q.delete();
        m_pc  = 32'h0;
        m_mis = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic pop_m;
            logic push_m;
            chk("rnd addr", Instr_Addr, m_pc);
            chk("rnd valid", 32'(out_valid), 32'(q.size() != 0));
            chk("rnd misalign", 32'(misalign_err), 32'(m_mis));
            if (q.size() != 0) begin
                chk("rnd pc", out_pc, q[0].pc);
                chk("rnd instr", out_instr, q[0].instr);
            end
            reset_n        = $urandom_range(0, 99) != 0;
            fetch_en       = $urandom_range(0, 9) < 8;
            out_ready      = $urandom_range(0, 9) < 6;
            redirect_valid = $urandom_range(0, 11) == 0;
            case ($urandom_range(0, 3))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: redirect_pc = 32'($urandom_range(0, 255));
            endcase
            if (!reset_n) begin
                q.delete();
                m_pc  = 32'h0;
                m_mis = 1'b0;
            end else begin
                pop_m  = (q.size() != 0) && out_ready;
                push_m = fetch_en && !redirect_valid && (q.size() < DEPTH || pop_m);
                if (pop_m) void'(q.pop_front());
                if (redirect_valid) begin
                    q.delete();
                    m_pc  = {redirect_pc[31:2], 2'b00};
                    m_mis = redirect_pc[1:0] != 2'b00;
                end else begin
                    m_mis = 1'b0;
                    if (push_m) begin
                        q.push_back('{pc: m_pc, instr: imem(m_pc)});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
